// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the memory-mapped UART transmitter.
//   IO_BASE      base of the IO window the decoder selects with io_select_o
//   REG_*        register index as seen on addr_i[3:2]
//   ST_*         bit positions inside the STATUS register
//   tx_state_e   serialiser FSM states
package mmio_pkg;

    localparam logic [31:0] IO_BASE = 32'hF000_0000;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, first-word-fall-through read port.
//   clk, rst_n   clock / async active-low reset
//   push, wdata  write request; ignored while full
//   pop, rdata   read request; ignored while empty; rdata is the head entry
//   full, empty  occupancy flags
//   count        entries held (one bit wider than the pointers)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a TX FIFO.
//   clk, rst_n        clock / async active-low reset
//   sel_i             IO window select from the address decoder
//   addr_i            byte address, addr_i[3:2] picks TXDATA/STATUS/BAUD/reserved
//   we_i, re_i        store / load strobes, qualified by sel_i
//   wdata_i           store data
//   rdata_o           load data, registered, valid the cycle after sel_i&re_i
//   tx_o              serial line, idles high
//   irq_o             transmit complete (FIFO empty and FSM idle)
module uart_tx_mmio
    import mmio_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int DIV_W        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic             wr_en, rd_en;
    logic [1:0]       reg_sel;
    logic             fifo_push, push_ok, fsm_pop;
    logic [7:0]       fifo_rdata;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count, cnt_nxt;
    logic [DIV_W-1:0] baud_q;
    logic             ovf_q;
    logic [31:0]      rd_mux;
    logic             unused_bits;

    tx_state_e        state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0] eff_div_q, eff_div_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             bit_end;

    assign unused_bits = ^{addr_i, wdata_i};

    assign wr_en     = sel_i & we_i;
    assign rd_en     = sel_i & re_i;
    assign reg_sel   = addr_i[3:2];
    assign fifo_push = wr_en && (reg_sel == REG_TXDATA);
    // Full is sampled before this cycle's pop, so a concurrent pop never rescues the write.
    assign push_ok   = fifo_push & ~fifo_full;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (wdata_i[7:0]),
        .pop   (fsm_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Registers: BAUD divider and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q <= DIV_W'(CLKS_PER_BIT);
            ovf_q  <= 1'b0;
        end else begin
            if (wr_en && reg_sel == REG_BAUD) baud_q <= wdata_i[DIV_W-1:0];
            if (fifo_push && fifo_full)
                ovf_q <= 1'b1;
            else if (wr_en && reg_sel == REG_STATUS && wdata_i[ST_OVF])
                ovf_q <= 1'b0;
        end
    end

    // Read mux sees pre-write state; the flop holds when no load happens.
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_STATUS: begin
                rd_mux[ST_BUSY]            = (state_q != TX_IDLE);
                rd_mux[ST_FULL]            = fifo_full;
                rd_mux[ST_EMPTY]           = fifo_empty;
                rd_mux[ST_OVF]             = ovf_q;
                rd_mux[ST_CNT_LSB +: CW]   = fifo_count;
            end
            REG_BAUD: rd_mux[DIV_W-1:0] = baud_q;
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rdata_o <= '0;
        else if (rd_en) rdata_o <= rd_mux;
    end

    // TX FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TX_IDLE;
            div_cnt_q <= '0;
            eff_div_q <= DIV_W'(1);
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            eff_div_q <= eff_div_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

    // Each symbol lasts eff_div cycles: div_cnt runs 0 .. eff_div-1.
    assign bit_end = (div_cnt_q == eff_div_q - DIV_W'(1));

    // TX FSM: next-state.
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        eff_div_d = eff_div_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        case (state_q)
            TX_IDLE: begin
                if (fsm_pop) begin
                    state_d   = TX_START;
                    shreg_d   = fifo_rdata;
                    eff_div_d = (baud_q == '0) ? DIV_W'(1) : baud_q;
                    div_cnt_d = '0;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d   = TX_DATA;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    div_cnt_d = '0;
                    shreg_d   = shreg_q >> 1;
                    if (bit_cnt_q == 3'd7) state_d = TX_STOP;
                    else                   bit_cnt_d = bit_cnt_q + 3'd1;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    state_d   = TX_IDLE;
                    div_cnt_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // TX FSM: outputs. tx_o depends only on flops, so reset forces it high at once.
    always_comb begin
        fsm_pop = (state_q == TX_IDLE) && !fifo_empty;
        case (state_q)
            TX_START: tx_o = 1'b0;
            TX_DATA:  tx_o = shreg_q[0];
            default:  tx_o = 1'b1;
        endcase
    end

    // irq_o is registered from next-state values so it lines up with the state it reports.
    assign cnt_nxt = fifo_count + CW'(push_ok) - CW'(fsm_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_o <= 1'b1;
        else        irq_o <= (state_d == TX_IDLE) && (cnt_nxt == '0);
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE = 32'hF000_0000;
    localparam logic [3:0]  A_TX = 4'h0, A_ST = 4'h4, A_BD = 4'h8, A_RS = 4'hC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel_i, we_i, re_i;
    logic [31:0] addr_i, wdata_i;
    logic [31:0] rdata_o;
    logic        tx_o, irq_o;

    int checks = 0;
    int failures = 0;

    uart_tx_mmio #(.FIFO_DEPTH(8), .CLKS_PER_BIT(434), .DIV_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel_i   (sel_i),
        .addr_i  (addr_i),
        .we_i    (we_i),
        .re_i    (re_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .tx_o    (tx_o),
        .irq_o   (irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic mmio_write(input logic [3:0] off, input logic [31:0] d);
        sel_i = 1'b1; we_i = 1'b1; addr_i = BASE + 32'(off); wdata_i = d;
        step();
        sel_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic mmio_read(input logic [3:0] off, output logic [31:0] d);
        sel_i = 1'b1; re_i = 1'b1; addr_i = BASE + 32'(off);
        step();
        sel_i = 1'b0; re_i = 1'b0;
        d = rdata_o;
    endtask

    task automatic mmio_rw(input logic [3:0] off, input logic [31:0] wd, output logic [31:0] d);
        sel_i = 1'b1; re_i = 1'b1; we_i = 1'b1; addr_i = BASE + 32'(off); wdata_i = wd;
        step();
        sel_i = 1'b0; re_i = 1'b0; we_i = 1'b0;
        d = rdata_o;
    endtask

    // Caller sits in the cycle after the TXDATA write (pop cycle); frame starts next cycle.
    task automatic check_frame(input logic [7:0] b, input int div, input string tag);
        logic exp;
        step();
        for (int k = 0; k < 10 * div; k++) begin
            if (k < div)          exp = 1'b0;
            else if (k < 9 * div) exp = b[k / div - 1];
            else                  exp = 1'b1;
            chk($sformatf("%s_tx_k%0d", tag, k), 32'(tx_o), 32'(exp));
            if (k == 10 * div - 1) chk($sformatf("%s_irq_last", tag), 32'(irq_o), 32'd0);
            step();
        end
        chk($sformatf("%s_irq_done", tag), 32'(irq_o), 32'd1);
        chk($sformatf("%s_tx_idle", tag), 32'(tx_o), 32'd1);
    endtask

    // Serial receiver used while several frames run back-to-back.
    logic       rx_en = 1'b0;
    int         rx_div = 2;
    logic [7:0] rx_q[$];

    always begin : rx_mon
        logic [7:0] b;
        @(posedge clk); #2;
        if (rx_en && tx_o === 1'b0) begin
            repeat (rx_div + rx_div / 2) @(posedge clk);
            #2;
            for (int i = 0; i < 8; i++) begin
                b[i] = tx_o;
                repeat (rx_div) @(posedge clk);
                #2;
            end
            rx_q.push_back(b);
        end
    end

    initial begin
        logic [31:0] rd;
        logic        done;
        logic        line_ok;

        sel_i = 0; we_i = 0; re_i = 0; addr_i = '0; wdata_i = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #10;
        chk("rst_tx", 32'(tx_o), 32'd1);
        chk("rst_irq", 32'(irq_o), 32'd1);
        chk("rst_rdata", rdata_o, 32'd0);
        rst_n = 1'b1;
        step();

        // Register reads after reset.
        mmio_read(A_ST, rd); chk("rd_status_rst", rd, 32'h4);
        mmio_read(A_BD, rd); chk("rd_baud_rst", rd, 32'd434);
        mmio_read(A_RS, rd); chk("rd_rsvd", rd, 32'h0);
        mmio_read(A_BD, rd);
        mmio_read(A_TX, rd); chk("rd_txdata", rd, 32'h0);
        step();
        chk("rdata_hold", rdata_o, 32'h0);

        // Single frame, BAUD=4.
        mmio_write(A_BD, 32'd4);
        mmio_write(A_TX, 32'h55);
        chk("t1_tx_pop_cycle", 32'(tx_o), 32'd1);
        chk("t1_irq_pending", 32'(irq_o), 32'd0);
        check_frame(8'h55, 4, "t1");

        // Back-to-back writes into the FIFO, BAUD=2.
        mmio_write(A_BD, 32'd2);
        rx_div = 2;
        rx_en  = 1'b1;
        for (int i = 0; i < 9; i++) mmio_write(A_TX, 32'h10 + 32'(i));
        mmio_read(A_ST, rd);  chk("t2_status_full", rd, 32'h83);
        mmio_write(A_TX, 32'hEE);
        mmio_read(A_ST, rd);  chk("t2_status_ovf", rd, 32'h8B);
        mmio_write(A_ST, 32'h7);
        mmio_read(A_ST, rd);  chk("t2_ovf_kept", rd, 32'h8B);
        mmio_write(A_ST, 32'h8);
        mmio_read(A_ST, rd);  chk("t2_ovf_clr", rd, 32'h83);
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            step();
            if (irq_o === 1'b1) done = 1'b1;
        end
        chk("t2_drain", 32'(done), 32'd1);
        rx_en = 1'b0;
        chk("t2_rx_count", 32'(rx_q.size()), 32'd9);
        foreach (rx_q[i]) chk($sformatf("t2_rx_byte%0d", i), 32'(rx_q[i]), 32'h10 + 32'(i));
        mmio_read(A_ST, rd);  chk("t2_status_idle", rd, 32'h4);

        // Simultaneous load+store returns the pre-write value.
        mmio_rw(A_BD, 32'hFFFF_0006, rd); chk("rw_old_baud", rd, 32'd2);
        mmio_read(A_BD, rd);  chk("rw_new_baud", rd, 32'd6);

        // BAUD=0 runs at 1 clk/bit; a mid-frame BAUD write is deferred.
        mmio_write(A_BD, 32'd0);
        mmio_write(A_TX, 32'hFF);
        fork
            check_frame(8'hFF, 1, "t4a");
            begin
                step(); step();
                mmio_write(A_BD, 32'd8);
            end
        join
        mmio_read(A_BD, rd);  chk("t4_baud8", rd, 32'd8);
        mmio_write(A_TX, 32'hA5);
        check_frame(8'hA5, 8, "t4b");

        // Reset in the middle of DATA; queued byte must vanish.
        mmio_write(A_TX, 32'h3C);
        mmio_write(A_TX, 32'h5A);
        repeat (20) step();
        mmio_read(A_ST, rd);  chk("t5_busy", rd, 32'h11);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_rst_tx", 32'(tx_o), 32'd1);
        chk("t5_rst_irq", 32'(irq_o), 32'd1);
        chk("t5_rst_rdata", rdata_o, 32'd0);
        step();
        #2 rst_n = 1'b1;
        step();
        mmio_read(A_ST, rd);  chk("t5_status", rd, 32'h4);
        mmio_read(A_BD, rd);  chk("t5_baud", rd, 32'd434);

        // Unselected stores have no effect.
        sel_i = 1'b0; we_i = 1'b1;
        addr_i = BASE + 32'(A_TX); wdata_i = 32'h77; step();
        addr_i = BASE + 32'(A_BD); wdata_i = 32'd5;  step();
        we_i = 1'b0; re_i = 1'b1; step();
        re_i = 1'b0;
        chk("t5_nosel_rdata", rdata_o, 32'd434);
        line_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (tx_o !== 1'b1 || irq_o !== 1'b1) line_ok = 1'b0;
            step();
        end
        chk("t5_nosel_line", 32'(line_ok), 32'd1);
        mmio_read(A_BD, rd);  chk("t5_nosel_baud", rd, 32'd434);
        mmio_read(A_ST, rd);  chk("t5_nosel_status", rd, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
